// File: rtl/reg_write_arbiter.sv
// Two-requester register-file write arbiter: round-robin grant, IDLE->WR->DONE per write.
// Grant registered on the IDLE edge; WRITE one cycle, ACK the next; requesters hold REQ until ACK.
module reg_write_arbiter (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       REQA,
  input  logic [2:0] ADDRA,
  input  logic [7:0] DATAA,
  output logic       ACKA,
  input  logic       REQB,
  input  logic [2:0] ADDRB,
  input  logic [7:0] DATAB,
  output logic       ACKB,
  output logic       WRITE,
  output logic [2:0] INADDRESS,
  output logic [7:0] IN,
  output logic [7:0] BUSY,
  output logic [7:0] WCOUNT
);

  typedef enum logic [1:0] {IDLE, WR, DONE} state_t;

  state_t     state_q;
  logic       last_b_q;
  logic       gnt_b_q;
  logic       write_q;
  logic       acka_q;
  logic       ackb_q;
  logic [2:0] addr_q;
  logic [7:0] data_q;
  logic [7:0] busy_q;
  logic [7:0] wcount_q;

  logic       gnt_b_d;
  logic [2:0] addr_d;
  logic [7:0] data_d;

  // B wins when it is alone, or on a tie when A was granted last.
  always_comb begin
    gnt_b_d = REQB & (~REQA | ~last_b_q);
    addr_d  = gnt_b_d ? ADDRB : ADDRA;
    data_d  = gnt_b_d ? DATAB : DATAA;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q  <= IDLE;
      last_b_q <= 1'b1;
      gnt_b_q  <= 1'b0;
      write_q  <= 1'b0;
      acka_q   <= 1'b0;
      ackb_q   <= 1'b0;
      addr_q   <= 3'd0;
      data_q   <= 8'd0;
      busy_q   <= 8'd0;
      wcount_q <= 8'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (REQA || REQB) begin
            state_q  <= WR;
            write_q  <= 1'b1;
            gnt_b_q  <= gnt_b_d;
            last_b_q <= gnt_b_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            busy_q   <= 8'd1 << addr_d;
          end
        end
        WR: begin
          state_q <= DONE;
          write_q <= 1'b0;
          acka_q  <= ~gnt_b_q;
          ackb_q  <= gnt_b_q;
        end
        DONE: begin
          state_q  <= IDLE;
          acka_q   <= 1'b0;
          ackb_q   <= 1'b0;
          busy_q   <= 8'd0;
          wcount_q <= wcount_q + 8'd1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ACKA      = acka_q;
  assign ACKB      = ackb_q;
  assign WRITE     = write_q;
  assign INADDRESS = addr_q;
  assign IN        = data_q;
  assign BUSY      = busy_q;
  assign WCOUNT    = wcount_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Scoreboard bench for reg_write_arbiter: a cycle-budget model predicts each grant,
// a negedge monitor checks the write/ack/count sequence the DUT produces.
module tb_reg_write_arbiter;

  logic       CLK;
  logic       RESET;
  logic       REQA, REQB;
  logic [2:0] ADDRA, ADDRB;
  logic [7:0] DATAA, DATAB;
  logic       ACKA, ACKB, WRITE;
  logic [2:0] INADDRESS;
  logic [7:0] IN, BUSY, WCOUNT;

  reg_write_arbiter dut (
    .CLK(CLK), .RESET(RESET),
    .REQA(REQA), .ADDRA(ADDRA), .DATAA(DATAA), .ACKA(ACKA),
    .REQB(REQB), .ADDRB(ADDRB), .DATAB(DATAB), .ACKB(ACKB),
    .WRITE(WRITE), .INADDRESS(INADDRESS), .IN(IN), .BUSY(BUSY), .WCOUNT(WCOUNT)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    int       c;
    bit       b;
    logic [2:0] addr;
    logic [7:0] data;
  } exp_t;

  exp_t       q[$];
  int         n_checks = 0;
  int         n_errors = 0;
  int         cyc = 0;
  int         idle_at = 0;
  bit         last_b = 1'b1;
  logic [7:0] exp_rf[8];
  logic [7:0] dut_rf[8];
  bit         ack_log[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  always @(posedge CLK) cyc <= cyc + 1;

  // Reference model: the arbiter is free once 3 cycles have passed since its last grant.
  initial forever begin
    @(posedge CLK or negedge RESET);
    if (!RESET) begin
      last_b  = 1'b1;
      idle_at = 0;
    end else if (cyc >= idle_at && (REQA || REQB)) begin
      exp_t e;
      e.b    = REQB && (!REQA || !last_b);
      e.addr = e.b ? ADDRB : ADDRA;
      e.data = e.b ? DATAB : DATAA;
      e.c    = cyc + 1;
      q.push_back(e);
      last_b  = e.b;
      idle_at = cyc + 3;
    end
  end

  // Monitor: WRITE at c, ACK at c+1, count/BUSY release at c+2.
  initial begin
    exp_t       cur;
    bit         have_cur;
    logic [7:0] exp_wcount;
    have_cur   = 1'b0;
    exp_wcount = 8'd0;
    cur.c = 0; cur.b = 1'b0; cur.addr = 3'd0; cur.data = 8'd0;
    forever begin
      @(negedge CLK);
      if (!RESET) begin
        q.delete();
        have_cur   = 1'b0;
        exp_wcount = 8'd0;
        chk("reset_outs", {17'd0, WRITE, ACKA, ACKB, INADDRESS, IN, BUSY, WCOUNT} == 32'd0 ? 32'd0
            : {5'd0, WRITE, ACKA, ACKB, INADDRESS, IN, BUSY, WCOUNT}, 32'd0);
      end else begin
        if (WRITE) dut_rf[INADDRESS] = IN;
        while (q.size() > 0 && q[0].c < cyc) begin
          n_checks++;
          n_errors++;
          $display("FAIL missed_write: got none expected write at cycle %0d", q[0].c);
          void'(q.pop_front());
        end
        if (q.size() > 0 && q[0].c == cyc) begin
          cur      = q.pop_front();
          have_cur = 1'b1;
          chk("write", 32'(WRITE), 32'd1);
          chk("inaddress", 32'(INADDRESS), 32'(cur.addr));
          chk("in_data", 32'(IN), 32'(cur.data));
          chk("busy_wr", 32'(BUSY), 32'(8'd1 << cur.addr));
          exp_rf[cur.addr] = cur.data;
        end else begin
          chk("no_write", 32'(WRITE), 32'd0);
        end
        chk("acka", 32'(ACKA), 32'(have_cur && cyc == cur.c + 1 && !cur.b));
        chk("ackb", 32'(ACKB), 32'(have_cur && cyc == cur.c + 1 && cur.b));
        chk("ack_excl", 32'(ACKA & ACKB), 32'd0);
        if (have_cur && cyc == cur.c + 1) begin
          chk("busy_done", 32'(BUSY), 32'(8'd1 << cur.addr));
          chk("hold_addr", 32'(INADDRESS), 32'(cur.addr));
          chk("hold_data", 32'(IN), 32'(cur.data));
        end
        if (have_cur && cyc == cur.c + 2) begin
          exp_wcount = exp_wcount + 8'd1;
          chk("wcount", 32'(WCOUNT), 32'(exp_wcount));
          chk("busy_idle", 32'(BUSY), 32'd0);
          have_cur = 1'b0;
        end
      end
    end
  end

  // Requesters: hold until ACK, drop on the edge ending it; new requests raised with probability pa/pb %.
  task automatic run(input int n, input int pa, input int pb);
    bit sa, sb;
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      sa = ACKA;
      sb = ACKB;
      if (sa) ack_log.push_back(1'b0);
      if (sb) ack_log.push_back(1'b1);
      @(posedge CLK);
      #1;
      if (REQA) begin
        if (sa) REQA = 1'b0;
      end else begin
        ADDRA = 3'($urandom);
        DATAA = 8'($urandom);
        if (int'($urandom_range(0, 99)) < pa) REQA = 1'b1;
      end
      if (REQB) begin
        if (sb) REQB = 1'b0;
      end else begin
        ADDRB = 3'($urandom);
        DATAB = 8'($urandom);
        if (int'($urandom_range(0, 99)) < pb) REQB = 1'b1;
      end
    end
  endtask

  task automatic do_reset();
    @(posedge CLK);
    #3;
    RESET = 1'b0;
    REQA  = 1'b0;
    REQB  = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RESET = 1'b1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_ack, prev_ack;
    bit done;
    for (int i = 0; i < 8; i++) begin
      exp_rf[i] = 8'd0;
      dut_rf[i] = 8'd0;
    end
    RESET = 1'b1;
    REQA = 1'b0; ADDRA = 3'd0; DATAA = 8'd0;
    REQB = 1'b0; ADDRB = 3'd0; DATAB = 8'd0;
    #2;
    do_reset();

    // Single write
    REQA = 1'b1; ADDRA = 3'd5; DATAA = 8'h3C;
    run(6, 0, 0);
    chk("single_wcount", 32'(WCOUNT), 32'd1);
    chk("single_rf", 32'(dut_rf[5]), 32'h3C);

    // Ties after reset, same address first
    do_reset();
    ack_log.delete();
    REQA = 1'b1; ADDRA = 3'd3; DATAA = 8'h11;
    REQB = 1'b1; ADDRB = 3'd3; DATAB = 8'h22;
    run(10, 0, 0);
    chk("same_addr_rf", 32'(dut_rf[3]), 32'h22);
    REQA = 1'b1; ADDRA = 3'd1; DATAA = 8'hAA;
    REQB = 1'b1; ADDRB = 3'd2; DATAB = 8'hBB;
    run(10, 0, 0);
    chk("tie_count", 32'(ack_log.size()), 32'd4);
    if (ack_log.size() == 4)
      chk("tie_order", {28'd0, ack_log[0], ack_log[1], ack_log[2], ack_log[3]}, 32'b0101);

    // Withdrawn B request, raised only while A is in WR
    ack_log.delete();
    REQA = 1'b1; ADDRA = 3'd6; DATAA = 8'h5A;
    @(posedge CLK); #1;
    REQB = 1'b1; ADDRB = 3'd7; DATAB = 8'h77;
    @(posedge CLK); #1;
    REQB = 1'b0;
    run(6, 0, 0);
    chk("withdraw_acks", 32'(ack_log.size()), 32'd1);
    if (ack_log.size() == 1) chk("withdraw_who", 32'(ack_log[0]), 32'd0);

    // Reset while in WR, then the same request reissued
    ack_log.delete();
    REQA = 1'b1; ADDRA = 3'd4; DATAA = 8'h44;
    @(posedge CLK); #3;
    RESET = 1'b0;
    #1;
    chk("abort_write", 32'(WRITE), 32'd0);
    chk("abort_busy", 32'(BUSY), 32'd0);
    chk("abort_wcount", 32'(WCOUNT), 32'd0);
    repeat (2) @(posedge CLK);
    #1;
    RESET = 1'b1;
    run(6, 0, 0);
    chk("reissue_acks", 32'(ack_log.size()), 32'd1);
    chk("reissue_rf", 32'(dut_rf[4]), 32'h44);

    // Random traffic, then a reset at an arbitrary point
    run(1500, 30, 30);
    do_reset();

    // 256 back-to-back A writes with REQA held high
    REQA = 1'b1; ADDRA = 3'd2; DATAA = 8'h99;
    n_ack = 0; prev_ack = 0; done = 1'b0;
    for (int i = 0; i < 1000 && !done; i++) begin
      @(negedge CLK);
      if (ACKA) begin
        n_ack++;
        if (n_ack > 1) chk("spacing", 32'(cyc - prev_ack), 32'd3);
        prev_ack = cyc;
      end
      @(posedge CLK); #1;
      if (ACKA == 1'b0 && n_ack == 256) begin
        REQA = 1'b0;
        done = 1'b1;
      end
    end
    chk("wrap_acks", 32'(n_ack), 32'd256);
    repeat (3) @(posedge CLK);
    #1;
    chk("wrap_wcount", 32'(WCOUNT), 32'd0);

    chk("queue_empty", 32'(q.size()), 32'd0);
    for (int i = 0; i < 8; i++) chk("regfile", 32'(dut_rf[i]), 32'(exp_rf[i]));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
